// File: rtl/hazard_scoreboard.sv
// Hazard unit for the in-order pipeline: tracks in-flight register writes from EX to WB
// and drives PC / IF-ID / ID-EX stall, bubble, flush and bypass-select controls.
module hazard_scoreboard #(
  parameter int ADDR_W    = 3,
  parameter int DEPTH     = 3,
  parameter int FWD       = 0,
  parameter int RF_BYPASS = 1,
  parameter int CNT_W     = 16,
  localparam int SEL_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs1,
  input  logic [ADDR_W-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [ADDR_W-1:0] id_rd,
  input  logic              id_rd_wr,
  input  logic              id_is_load,
  input  logic              br_flush,
  output logic              pc_wr,
  output logic              if_id_wr,
  output logic              if_id_flush,
  output logic              nop,
  output logic [SEL_W-1:0]  fwd_a,
  output logic [SEL_W-1:0]  fwd_b,
  output logic [CNT_W-1:0]  stall_cnt
);

  // With a write-through register file the WB entry is already visible to decode.
  localparam int LAST = (RF_BYPASS != 0) ? DEPTH - 2 : DEPTH - 1;

  logic [DEPTH-1:0]  v_q, ld_q;
  logic [ADDR_W-1:0] rd_q [DEPTH];
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic             hit_a, hit_b, hz, stall;
  logic [SEL_W-1:0] idx_a, idx_b;

  // Scan oldest to youngest so the lowest matching stage is the one left standing.
  always_comb begin
    // NOTE: every comb output gets a default first, otherwise a latch is inferred.
    hit_a = 1'b0;
    hit_b = 1'b0;
    idx_a = '0;
    idx_b = '0;
    for (int k = LAST; k >= 0; k--) begin
      if (id_rs1_used && v_q[k] && (rd_q[k] == id_rs1)) begin
        hit_a = 1'b1;
        idx_a = SEL_W'(k + 1);
      end
      if (id_rs2_used && v_q[k] && (rd_q[k] == id_rs2)) begin
        hit_b = 1'b1;
        idx_b = SEL_W'(k + 1);
      end
    end
  end

  always_comb begin
    if (FWD != 0)
      hz = id_valid && ld_q[0] &&
           ((hit_a && idx_a == SEL_W'(1)) || (hit_b && idx_b == SEL_W'(1)));
    else
      hz = id_valid && (hit_a || hit_b);
  end

  // A taken branch kills the ID instruction, so its hazard never stalls.
  assign stall       = hz && !br_flush;
  assign pc_wr       = !stall;
  assign if_id_wr    = !stall;
  assign if_id_flush = br_flush;
  assign nop         = stall || br_flush || !id_valid;

  // Selects are zeroed whenever ID/EX receives a bubble; the bypass would be unused.
  assign fwd_a = (FWD != 0 && !nop) ? idx_a : '0;
  assign fwd_b = (FWD != 0 && !nop) ? idx_b : '0;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != {CNT_W{1'b1}})
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  // NOTE: the tag array is tiny control state, so the whole array is reset rather than
  // relying on v alone; a stale rd could otherwise alias after reset in a sloppy edit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignment so the shift reads old values.
      v_q         <= '0;
      ld_q        <= '0;
      stall_cnt_q <= '0;
      for (int k = 0; k < DEPTH; k++) rd_q[k] <= '0;
    end else begin
      v_q         <= {v_q[DEPTH-2:0], id_valid && id_rd_wr && !nop};
      ld_q        <= {ld_q[DEPTH-2:0], id_is_load};
      stall_cnt_q <= stall_cnt_d;
      for (int k = DEPTH - 1; k > 0; k--) rd_q[k] <= rd_q[k-1];
      rd_q[0]     <= id_rd;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: three configurations share one input stream; each vector
// targets one instance, expectations go through a queue and are compared at negedge.
module tb_hazard_scoreboard;

  localparam int S = 0;  // FWD=0, DEPTH=3, RF_BYPASS=1, CNT_W=4
  localparam int F = 1;  // FWD=1, DEPTH=3, RF_BYPASS=1
  localparam int N = 2;  // FWD=0, DEPTH=4, RF_BYPASS=0

  typedef struct {
    int rst, dut, v, rs1, u1, rs2, u2, rd, wr, ld, br;
    int es, en, ef, fa, fb, cc, cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_valid = 1'b0, id_rs1_used = 1'b0, id_rs2_used = 1'b0;
  logic id_rd_wr = 1'b0, id_is_load = 1'b0, br_flush = 1'b0;
  logic [2:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;

  logic s_pc, s_ifid, s_fl, s_nop, f_pc, f_ifid, f_fl, f_nop, n_pc, n_ifid, n_fl, n_nop;
  logic [1:0]  s_fa, s_fb, f_fa, f_fb;
  logic [2:0]  n_fa, n_fb;
  logic [3:0]  s_cnt;
  logic [15:0] f_cnt, n_cnt;

  int n_vec = 0;
  int n_err = 0;
  vec_t tbl[$];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  hazard_scoreboard #(.ADDR_W(3), .DEPTH(3), .FWD(0), .RF_BYPASS(1), .CNT_W(4)) u_s (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_rd_wr(id_rd_wr), .id_is_load(id_is_load), .br_flush(br_flush),
    .pc_wr(s_pc), .if_id_wr(s_ifid), .if_id_flush(s_fl), .nop(s_nop),
    .fwd_a(s_fa), .fwd_b(s_fb), .stall_cnt(s_cnt));

  hazard_scoreboard #(.ADDR_W(3), .DEPTH(3), .FWD(1), .RF_BYPASS(1), .CNT_W(16)) u_f (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_rd_wr(id_rd_wr), .id_is_load(id_is_load), .br_flush(br_flush),
    .pc_wr(f_pc), .if_id_wr(f_ifid), .if_id_flush(f_fl), .nop(f_nop),
    .fwd_a(f_fa), .fwd_b(f_fb), .stall_cnt(f_cnt));

  hazard_scoreboard #(.ADDR_W(3), .DEPTH(4), .FWD(0), .RF_BYPASS(0), .CNT_W(16)) u_n (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_rd_wr(id_rd_wr), .id_is_load(id_is_load), .br_flush(br_flush),
    .pc_wr(n_pc), .if_id_wr(n_ifid), .if_id_flush(n_fl), .nop(n_nop),
    .fwd_a(n_fa), .fwd_b(n_fb), .stall_cnt(n_cnt));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] ctl_of(input int dut);
    case (dut)
      S:       return {s_pc, s_ifid, s_fl, s_nop, 1'b0, s_fa, 1'b0, s_fb};
      F:       return {f_pc, f_ifid, f_fl, f_nop, 1'b0, f_fa, 1'b0, f_fb};
      default: return {n_pc, n_ifid, n_fl, n_nop, n_fa, n_fb};
    endcase
  endfunction

  function automatic logic [15:0] cnt_of(input int dut);
    case (dut)
      S:       return {12'd0, s_cnt};
      F:       return f_cnt;
      default: return n_cnt;
    endcase
  endfunction

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    #2 rst = 1'b0;
  endtask

  // Drive one ID cycle, queue its expectation, and compare the popped entry at negedge.
  task automatic apply(input vec_t e);
    vec_t x;
    logic [9:0] want;
    if (e.rst != 0) do_reset();
    else begin
      @(posedge clk);
      #1;
    end
    id_valid    = 1'(e.v);
    id_rs1      = 3'(e.rs1);
    id_rs1_used = 1'(e.u1);
    id_rs2      = 3'(e.rs2);
    id_rs2_used = 1'(e.u2);
    id_rd       = 3'(e.rd);
    id_rd_wr    = 1'(e.wr);
    id_is_load  = 1'(e.ld);
    br_flush    = 1'(e.br);
    exp_q.push_back(e);
    @(negedge clk);
    x = exp_q.pop_front();
    want = {~1'(x.es), ~1'(x.es), 1'(x.ef), 1'(x.en), 3'(x.fa), 3'(x.fb)};
    check($sformatf("ctl[%0d] dut%0d {pc,ifid,flush,nop,fa,fb}", n_vec, x.dut),
          32'(ctl_of(x.dut)), 32'(want));
    if (x.cc != 0)
      check($sformatf("stall_cnt dut%0d", x.dut), 32'(cnt_of(x.dut)), 32'(x.cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //                rst dut v rs1 u1 rs2 u2 rd wr ld br  st nop fl fa fb cc cnt
    tbl.push_back(vec_t'{1, S, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 1, 0});
    // load-use: one stall, then both operands from MEM
    tbl.push_back(vec_t'{1, F, 1, 0, 0, 0, 0, 3, 1, 1, 0,  0, 0, 0, 0, 0, 0, 0});
    tbl.push_back(vec_t'{0, F, 1, 3, 1, 3, 1, 4, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0});
    tbl.push_back(vec_t'{0, F, 1, 3, 1, 3, 1, 4, 1, 0, 0,  0, 0, 0, 2, 2, 0, 0});
    tbl.push_back(vec_t'{0, F, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 1, 1});
    // two writers of r5: youngest wins
    tbl.push_back(vec_t'{1, F, 1, 0, 0, 0, 0, 5, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0});
    tbl.push_back(vec_t'{0, F, 1, 0, 0, 0, 0, 5, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0});
    tbl.push_back(vec_t'{0, F, 1, 5, 1, 0, 0, 6, 1, 0, 0,  0, 0, 0, 1, 0, 0, 0});
    tbl.push_back(vec_t'{0, F, 1, 5, 1, 5, 1, 7, 0, 0, 0,  0, 0, 0, 2, 2, 1, 0});
    // branch flush beats load-use; the killed instruction allocates no tag
    tbl.push_back(vec_t'{1, F, 1, 0, 0, 0, 0, 2, 1, 1, 0,  0, 0, 0, 0, 0, 0, 0});
    tbl.push_back(vec_t'{0, F, 1, 2, 1, 0, 0, 7, 1, 0, 1,  0, 1, 1, 0, 0, 0, 0});
    tbl.push_back(vec_t'{0, F, 1, 7, 1, 2, 1, 1, 0, 0, 0,  0, 0, 0, 0, 2, 1, 0});
    // no write-through: DEPTH stall cycles
    tbl.push_back(vec_t'{1, N, 1, 0, 0, 0, 0, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0});
    for (int i = 0; i < 4; i++)
      tbl.push_back(vec_t'{0, N, 1, 1, 1, 0, 0, 2, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0});
    tbl.push_back(vec_t'{0, N, 1, 1, 1, 0, 0, 2, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0});
    tbl.push_back(vec_t'{0, N, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 1, 4});
    // unused sources never stall
    tbl.push_back(vec_t'{1, S, 1, 0, 0, 0, 0, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0});
    tbl.push_back(vec_t'{0, S, 1, 1, 0, 1, 0, 2, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0});
    // invalid ID slot: bubble, and nothing allocated
    tbl.push_back(vec_t'{1, S, 0, 0, 0, 0, 0, 1, 1, 0, 0,  0, 1, 0, 0, 0, 0, 0});
    tbl.push_back(vec_t'{0, S, 1, 1, 1, 1, 1, 2, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0});
    // stall-until-writeback with write-through: DEPTH-1 cycles
    tbl.push_back(vec_t'{1, S, 1, 0, 0, 0, 0, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0});
    tbl.push_back(vec_t'{0, S, 1, 1, 1, 0, 0, 2, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0});
    tbl.push_back(vec_t'{0, S, 1, 1, 1, 0, 0, 2, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0});
    tbl.push_back(vec_t'{0, S, 1, 1, 1, 0, 0, 2, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0});
    tbl.push_back(vec_t'{0, S, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 1, 2});
    // three valid tags, consumer stalls on the youngest (counter still holds 2)
    tbl.push_back(vec_t'{0, S, 1, 0, 0, 0, 0, 5, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0});
    tbl.push_back(vec_t'{0, S, 1, 0, 0, 0, 0, 6, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0});
    tbl.push_back(vec_t'{0, S, 1, 0, 0, 0, 0, 7, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0});
    tbl.push_back(vec_t'{0, S, 1, 7, 1, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 1, 2});

    foreach (tbl[i]) apply(tbl[i]);

    // asynchronous reset in the middle of the stall cycle
    #1 rst = 1'b1;
    #1;
    check("mid-stall reset {pc,ifid,nop}", 32'({s_pc, s_ifid, s_nop}), 32'(3'b110));
    check("mid-stall reset stall_cnt", 32'(s_cnt), 32'(0));
    #1 rst = 1'b0;
    apply(vec_t'{0, S, 1, 7, 1, 5, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0});

    // saturation: 2 stalls per round, counter clamps at 15 and stays there
    for (int r = 0; r <= 10; r++) begin
      apply(vec_t'{(r == 0) ? 1 : 0, S, 1, 0, 0, 0, 0, 1, 1, 0, 0,
                   0, 0, 0, 0, 0, 1, (2 * r > 15) ? 15 : 2 * r});
      apply(vec_t'{0, S, 1, 1, 1, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0});
      apply(vec_t'{0, S, 1, 1, 1, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0});
      apply(vec_t'{0, S, 1, 1, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0});
    end
    apply(vec_t'{0, S, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 1, 15});

    if (exp_q.size() != 0) check("scoreboard drained", 32'(exp_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
